// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end.
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : one buffered instruction together with its address
package fetch_pkg;
  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request on the bus
    REQ  = 2'd1,  // request at fetch_pc
    DROP = 2'd2   // stale request in flight, its data is thrown away
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i/push_data_i: write one entry (caller never pushes when full)
//   pop_i             : drop head entry (caller never pops when empty)
//   flush_i           : clear pointers and count; overrides push/pop
//   head_o            : head entry, all-zero while empty
//   empty_o, full_o, count_o : occupancy
module instr_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem[wr_ptr] <= push_data_i;
  end

  assign empty_o = (count == '0);
  assign full_o  = (count == CW'(DEPTH));
  assign count_o = count;
  assign head_o  = empty_o ? '0 : mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues req/ack fetches to
// instruction memory, buffers results in instr_fifo and hands them to
// decode with valid/ready. A redirect flushes the queue and refetches.
//   clk_i, rst_i               : clock, synchronous active-high reset
//   start_i                    : fetch enable (low blocks new requests only)
//   mem_req_o, mem_addr_o      : fetch request, held until mem_ack_i
//   mem_ack_i, mem_rdata_i     : request accepted, data valid same cycle
//   instr_valid_o/instr_o/instr_pc_o, instr_ready_i : decode handshake
//   redirect_i, redirect_pc_i  : flush and restart at redirect_pc_i & ~3
// All outputs are registered or decoded from state only.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic               mem_req_o,
  output logic [31:0]        mem_addr_o,
  input  logic               mem_ack_i,
  input  logic [INSTR_W-1:0] mem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        instr_pc_o,
  input  logic               instr_ready_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i
);
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt, addr_q, redir_pc;
  logic          push, pop, space, fifo_empty, fifo_full;
  logic [CW-1:0] count, count_nxt;
  fetch_entry_t  push_data, head;

  assign redir_pc  = redirect_pc_i & ~32'd3;
  assign push_data = '{pc: fetch_pc, instr: mem_rdata_i};

  // A redirect kills both the incoming word and any consumption this cycle.
  assign pop  = !fifo_empty && instr_ready_i && !redirect_i;
  assign push = (state == REQ) && mem_ack_i && !redirect_i && !fifo_full;

  // Issue a request only if its word is guaranteed a slot once it lands.
  assign count_nxt = redirect_i ? '0 : count + CW'(push) - CW'(pop);
  assign space     = (count_nxt < DEPTH_C);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    if (redirect_i) fetch_pc_nxt = redir_pc;
    case (state)
      IDLE: if (start_i && space) state_nxt = REQ;
      REQ: begin
        if (mem_ack_i) begin
          if (!redirect_i) fetch_pc_nxt = fetch_pc + PC_INCR;
          state_nxt = (start_i && space) ? REQ : IDLE;
        end else if (redirect_i) begin
          // Request cannot be withdrawn; park on it until its ack.
          state_nxt = DROP;
        end
      end
      DROP: if (mem_ack_i) state_nxt = (start_i && space) ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      // DROP keeps the stale address on the bus; elsewhere the bus address
      // tracks fetch_pc (which is stable while a REQ is outstanding).
      if (state_nxt != DROP) addr_q <= fetch_pc_nxt;
    end
  end

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .flush_i    (redirect_i),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .count_o    (count)
  );

  assign mem_req_o     = (state != IDLE);
  assign mem_addr_o    = addr_q;
  assign instr_valid_o = !fifo_empty;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;
endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, zw = 1'b0, ack_man = 1'b0;
  logic        rdy = 1'b0, redir = 1'b0;
  logic [31:0] rpc = '0;
  logic        req, ack, valid;
  logic [31:0] addr, rdata, instr, ipc;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model: zero-wait mode acks every request, otherwise ack is manual.
  assign ack   = zw ? req : (ack_man & req);
  assign rdata = addr ^ K;

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .mem_req_o    (req),
    .mem_addr_o   (addr),
    .mem_ack_i    (ack),
    .mem_rdata_i  (rdata),
    .instr_valid_o(valid),
    .instr_o      (instr),
    .instr_pc_o   (ipc),
    .instr_ready_i(rdy),
    .redirect_i   (redir),
    .redirect_pc_i(rpc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic outs(input string nm, input logic ereq, input logic [31:0] eaddr,
                      input logic ev, input logic [31:0] epc);
    chk({nm, ".req"},   32'(req),   32'(ereq));
    chk({nm, ".addr"},  addr,       eaddr);
    chk({nm, ".valid"}, 32'(valid), 32'(ev));
    if (ev) begin
      chk({nm, ".pc"},    ipc,   epc);
      chk({nm, ".instr"}, instr, epc ^ K);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".req"},   32'(req),   32'd0);
    chk({nm, ".addr"},  addr,       32'h0);
    chk({nm, ".valid"}, 32'(valid), 32'd0);
    chk({nm, ".instr"}, instr,      32'h0);
    chk({nm, ".pc"},    ipc,        32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; zw = 1'b0; ack_man = 1'b0;
    rdy = 1'b0; redir = 1'b0; rpc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        start, rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc;
  } vec_t;
  vec_t tbl [14];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Zero-wait streaming, then back-pressure until the queue fills.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'd4,  1'b1, 32'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd4};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd8};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'd16, 1'b1, 32'd12};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'd20, 1'b1, 32'd12};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'd24, 1'b1, 32'd12};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'd28, 1'b1, 32'd12};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'd28, 1'b1, 32'd12};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'd28, 1'b1, 32'd12};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'd28, 1'b1, 32'd16};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'd32, 1'b1, 32'd16};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'd32, 1'b1, 32'd16};

    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    zw  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      start = tbl[i].start;
      rdy   = tbl[i].rdy;
      outs($sformatf("t%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].ev, tbl[i].epc);
      @(negedge clk);
    end

    // Slow memory, redirect while waiting: DROP holds the stale address,
    // then start_i drops with a request still outstanding.
    do_reset();
    start = 1'b1; rdy = 1'b1;
    outs("a0", 1'b0, 32'h0, 1'b0, 32'h0); @(negedge clk);
    outs("a1", 1'b1, 32'h0, 1'b0, 32'h0); @(negedge clk);
    redir = 1'b1; rpc = 32'h100;
    outs("a2", 1'b1, 32'h0, 1'b0, 32'h0); @(negedge clk);
    redir = 1'b0; ack_man = 1'b1;
    outs("a3", 1'b1, 32'h0, 1'b0, 32'h0); @(negedge clk);
    outs("a4", 1'b1, 32'h100, 1'b0, 32'h0); @(negedge clk);
    ack_man = 1'b0; start = 1'b0;
    outs("a5", 1'b1, 32'h104, 1'b1, 32'h100); @(negedge clk);
    ack_man = 1'b1;
    outs("a6", 1'b1, 32'h104, 1'b0, 32'h0); @(negedge clk);
    ack_man = 1'b0;
    outs("a7", 1'b0, 32'h108, 1'b1, 32'h104); @(negedge clk);
    outs("a8", 1'b0, 32'h108, 1'b0, 32'h0); @(negedge clk);

    // Redirect coinciding with ack and pop, two entries queued;
    // then redirect near the top of the address space to check wrap.
    do_reset();
    start = 1'b1; zw = 1'b1; rdy = 1'b0;
    outs("b0", 1'b0, 32'h0, 1'b0, 32'h0); @(negedge clk);
    outs("b1", 1'b1, 32'h0, 1'b0, 32'h0); @(negedge clk);
    outs("b2", 1'b1, 32'h4, 1'b1, 32'h0); @(negedge clk);
    rdy = 1'b1; redir = 1'b1; rpc = 32'h203;
    outs("b3", 1'b1, 32'h8, 1'b1, 32'h0); @(negedge clk);
    redir = 1'b0; rdy = 1'b0;
    outs("b4", 1'b1, 32'h200, 1'b0, 32'h0); @(negedge clk);
    rdy = 1'b1; redir = 1'b1; rpc = 32'hFFFF_FFF8;
    outs("b5", 1'b1, 32'h204, 1'b1, 32'h200); @(negedge clk);
    redir = 1'b0;
    outs("c0", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0); @(negedge clk);
    outs("c1", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8); @(negedge clk);
    outs("c2", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC); @(negedge clk);
    outs("c3", 1'b1, 32'h4, 1'b1, 32'h0); @(negedge clk);

    // Reset while parked in DROP on a non-reset address.
    do_reset();
    start = 1'b1; zw = 1'b1; rdy = 1'b0;
    outs("d0", 1'b0, 32'h0, 1'b0, 32'h0); @(negedge clk);
    outs("d1", 1'b1, 32'h0, 1'b0, 32'h0); @(negedge clk);
    outs("d2", 1'b1, 32'h4, 1'b1, 32'h0); @(negedge clk);
    zw = 1'b0; ack_man = 1'b0; redir = 1'b1; rpc = 32'h40;
    outs("d3", 1'b1, 32'h8, 1'b1, 32'h0); @(negedge clk);
    redir = 1'b0; rst = 1'b1;
    outs("d4", 1'b1, 32'h8, 1'b0, 32'h0); @(negedge clk);
    chk_reset("d5");
    rst = 1'b0;
    @(negedge clk);
    outs("d6", 1'b1, 32'h0, 1'b0, 32'h0); @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front end for the RISC-V core. It owns the program counter, fetches 32-bit words from an instruction memory over a req/ack handshake, and buffers them in a small FIFO. It presents them to the decode/register stage (`Control`, `Registers`, `Sign_Extend`) with a valid/ready handshake. A redirect input from branch/jump resolution flushes the queue and restarts fetch.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: fetch address after reset.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  fetch enable; low blocks new requests only.
- `mem_req_o`  out  1  fetch request.
- `mem_addr_o`  out  32  fetch address, word-aligned.
- `mem_ack_i`  in  1  request accepted; `mem_rdata_i` valid in the same cycle.
- `mem_rdata_i`  in  32  fetched instruction.
- `instr_valid_o`  out  1  FIFO head valid.
- `instr_o`  out  32  head instruction.
- `instr_pc_o`  out  32  address of head instruction.
- `instr_ready_i`  in  1  decode consumes head when valid and ready.
- `redirect_i`  in  1  flush and refetch from `redirect_pc_i`.
- `redirect_pc_i`  in  32  new fetch address; bits [1:0] forced to 0.

## Operation
- States: IDLE (no request), REQ (`mem_req_o`=1, address `fetch_pc`), DROP (`mem_req_o`=1 holding the stale address; ack data discarded).
- Memory rule: once `mem_req_o` rises, `mem_req_o` and `mem_addr_o` stay stable until the cycle `mem_ack_i`=1. A request is never withdrawn.
- Space check: `count_next` = count + push − pop. A request may be active only if `count_next` < DEPTH.
- IDLE→REQ when `start_i`=1 and space is available.
- REQ + ack (no redirect): push {`mem_rdata_i`, `fetch_pc`}, `fetch_pc` += 4. Stay in REQ if `start_i` and space remain; otherwise go to IDLE.
- Redirect: FIFO count and pointers clear; `fetch_pc` ← `redirect_pc_i` & ~3; a pop in the same cycle has no effect.
  - From REQ without ack: go to DROP.
  - From REQ with ack: data discarded, go to REQ or IDLE per the space/`start_i` rule, using the new pc.
  - From IDLE or DROP: only the pc is updated; DROP still awaits its ack.
- DROP + ack: discard data, go to REQ (or IDLE) at `fetch_pc`.
- Pop when `instr_valid_o` && `instr_ready_i` && !`redirect_i`. Push and pop in the same cycle leave count unchanged.
- Full FIFO: `mem_req_o` is 0; it reasserts in the cycle after the pop edge.
- `start_i` low during REQ: the outstanding request completes and is pushed; then IDLE.
- pc arithmetic: 32-bit, wraps 32'hFFFF_FFFC → 0.

## Timing
- Reset values: state IDLE, `mem_req_o`=0, `mem_addr_o`=RESET_PC, `instr_valid_o`=0, `instr_o`=0, `instr_pc_o`=0, count=0.
- Reset mid-transaction: abandons any outstanding request. The memory must be reset in the same cycle.
- `start_i` rises at edge N: `mem_req_o`=1 during cycle N+1.
- Ack in cycle K: `instr_valid_o`=1 from cycle K+1. There is no bypass, so fetch-to-decode latency is 1 cycle after ack.
- Zero-wait memory (ack in every request cycle): one instruction per cycle sustained. `mem_req_o` stays high.
- Redirect at edge R: `instr_valid_o`=0 in cycle R+1. The first new-path request appears in cycle R+1, or after the DROP ack.
- `mem_req_o`, `mem_addr_o`, `instr_*` are registered or pure state-decoded. No combinational path from `instr_ready_i` or `mem_ack_i` to any output.

## Structure
- Package `fetch_pkg`:
  - enum `fetch_state_t` {IDLE, REQ, DROP}
  - `INSTR_W`=32
  - `PC_INCR`=32'd4
- Sub-module `instr_fifo`: synchronous FIFO of {pc, instr}, DEPTH entries, with push/pop/flush, full/empty and count outputs. The fetch FSM and pc logic sit in `instr_fetch_queue`.

## Test plan
- Reset, `start_i`=1, zero-wait memory returning addr^32'hA5A5_0000, ready=1 → instr_pc_o sequence 0,4,8,12 on consecutive cycles; first valid 2 cycles after start edge.
- Ready=0 with zero-wait memory → exactly DEPTH=4 pushes, `mem_req_o`=0. Raise ready for 1 cycle → one pop, one new request at 16.
- Memory with 3-cycle ack latency, redirect to 32'h100 in 2nd wait cycle:
  - DROP: stale address held until ack.
  - Stale data never appears on `instr_o`.
  - Next request address is 32'h100.
- Redirect to 32'h203 in the same cycle as ack and pop with FIFO holding 2 entries → `instr_valid_o`=0 next cycle, next fetch 32'h200, stale data discarded.
- `start_i` dropped while a request is outstanding → the request completes and is delivered; no further `mem_req_o`.
- Redirect to 32'hFFFF_FFF8, zero-wait → pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `rst_i` while in DROP → all outputs at reset values next cycle.
